// File: rtl/word_packer_pkg.sv
// Shared sizing constants and the debug state encoding of the word packer.
package word_packer_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int N_WORD_DEF  = 8;
  localparam int NB_TOTAL    = NB_DATA_DEF * N_WORD_DEF;
  localparam int NB_PTR      = $clog2(N_WORD_DEF);
  localparam int NB_CNT      = $clog2(N_WORD_DEF + 1);

  // Bit 1 = an output frame is held, bit 0 = a frame is being filled.
  // Both can be set together: filling continues while the output waits.
  typedef enum logic [1:0] {
    ST_EMPTY        = 2'b00,
    ST_FILLING      = 2'b01,
    ST_HOLD         = 2'b10,
    ST_HOLD_FILLING = 2'b11
  } state_e;

  function automatic state_e state_of(input logic hold, input logic filling);
    return state_e'({hold, filling});
  endfunction

endpackage

// File: rtl/word_packer_frame_hold_reg.sv
// Registered output stage: loads a frame, holds it under backpressure and
// releases it on the downstream handshake.
module frame_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_load_ok
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A new frame may be loaded when the slot is free or drains this cycle.
  assign o_load_ok = reset && (!r_valid || i_ready);
  assign o_data    = r_data;
  assign o_valid   = r_valid;

  // Load has priority over drain so back-to-back frames never bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/word_packer.sv
// Collects serial NB_DATA-bit samples into an N_WORD-word frame (word 0 in
// the LSBs) and presents it on a registered valid/ready output.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready are both high; valid, once raised, holds together
// with its payload until that transfer; ready never depends on valid.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int N_WORD  = N_WORD_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NB_DATA-1:0]           i_data,
  input  logic                         i_valid,
  input  logic                         i_last,
  output logic                         o_ready,
  output logic [NB_DATA*N_WORD-1:0]    o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(N_WORD+1)-1:0]  o_nwords,
  output logic                         o_partial,
  output state_e                       o_dbg_state
);

  localparam int W_TOTAL = NB_DATA * N_WORD;
  localparam int W_PTR   = $clog2(N_WORD);
  localparam int W_CNT   = $clog2(N_WORD + 1);
  localparam int W_HOLD  = 1 + W_CNT + W_TOTAL;

  logic [W_PTR-1:0]   r_wr_ptr;
  logic [W_TOTAL-1:0] r_acc;
  state_e             r_state;
  state_e             w_state_nxt;

  logic               w_ready;
  logic               w_valid;
  logic               w_accept;
  logic               w_last_slot;
  logic               w_complete;
  logic [W_TOTAL-1:0] w_frame;
  logic [W_CNT-1:0]   w_nwords;
  logic               w_partial;
  logic [W_HOLD-1:0]  w_hold_q;

  assign w_last_slot = (r_wr_ptr == W_PTR'(N_WORD - 1));
  assign w_accept    = i_valid && w_ready;
  assign w_complete  = w_accept && (w_last_slot || i_last);
  assign w_nwords    = W_CNT'(r_wr_ptr) + W_CNT'(1);
  assign w_partial   = !w_last_slot;

  // Slots above wr_ptr are always zero in r_acc (only slot wr_ptr is ever
  // written and the whole accumulator clears on completion), so the outgoing
  // frame is r_acc with slot wr_ptr replaced by the incoming sample.
  for (genvar k = 0; k < N_WORD; k++) begin : g_slot
    logic w_sel;
    assign w_sel = (r_wr_ptr == W_PTR'(k));
    assign w_frame[(k+1)*NB_DATA-1 -: NB_DATA] =
      w_sel ? i_data : r_acc[(k+1)*NB_DATA-1 -: NB_DATA];

    // Per-slot write enable; completion zero-fills for the next frame.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_acc[(k+1)*NB_DATA-1 -: NB_DATA] <= '0;
      end else if (w_complete) begin
        r_acc[(k+1)*NB_DATA-1 -: NB_DATA] <= '0;
      end else if (w_accept && w_sel) begin
        r_acc[(k+1)*NB_DATA-1 -: NB_DATA] <= i_data;
      end
    end
  end

  // Write pointer: advance on accept, restart at slot 0 on completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
    end else if (w_complete) begin
      r_wr_ptr <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + W_PTR'(1);
    end
  end

  frame_hold_reg #(
    .WIDTH (W_HOLD)
  ) u_hold (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_complete),
    .i_load_data ({w_partial, w_nwords, w_frame}),
    .i_ready     (i_ready),
    .o_data      (w_hold_q),
    .o_valid     (w_valid),
    .o_load_ok   (w_ready)
  );

  assign o_ready   = w_ready;
  assign o_valid   = w_valid;
  assign o_data    = w_hold_q[W_TOTAL-1:0];
  assign o_nwords  = w_hold_q[W_TOTAL +: W_CNT];
  assign o_partial = w_hold_q[W_HOLD-1];

  // Next debug state from the next values of wr_ptr!=0 and o_valid.
  always_comb begin
    w_state_nxt = ST_EMPTY;
    w_state_nxt = state_of(w_complete || (w_valid && !i_ready),
                           !w_complete && (w_accept || (r_wr_ptr != '0)));
  end

  // Debug state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: queue-based reference model feeding
// an expected-frame queue, and a monitor comparing every presented frame.
module tb_word_packer;
  import word_packer_pkg::*;

  localparam int NB = NB_DATA_DEF;
  localparam int NW = N_WORD_DEF;
  localparam int W  = NB_TOTAL + NB_CNT + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NB-1:0]       i_data  = '0;
  logic                i_valid = 1'b0;
  logic                i_last  = 1'b0;
  logic                i_ready = 1'b0;
  logic                o_ready;
  logic [NB_TOTAL-1:0] o_data;
  logic                o_valid;
  logic [NB_CNT-1:0]   o_nwords;
  logic                o_partial;
  state_e              o_dbg_state;

  word_packer #(.NB_DATA(NB), .N_WORD(NW)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_nwords    (o_nwords),
    .o_partial   (o_partial),
    .o_dbg_state (o_dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]  exp_q[$];
  logic [NB-1:0] m_cur[$];
  bit            m_valid;

  function automatic logic [W-1:0] build_frame();
    logic [NB_TOTAL-1:0] f;
    f = '0;
    foreach (m_cur[i]) f = f | (NB_TOTAL'(m_cur[i]) << (i * NB));
    return {(m_cur.size() != NW), NB_CNT'(m_cur.size()), f};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_valid = 1'b0;
      m_cur.delete();
      exp_q.delete();
    end else begin
      bit rdy;
      rdy = !m_valid || i_ready;
      if (m_valid && i_ready) m_valid = 1'b0;
      if (i_valid && rdy) begin
        m_cur.push_back(i_data);
        if (m_cur.size() == NW || i_last) begin
          exp_q.push_back(build_frame());
          m_cur.delete();
          m_valid = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    chk("o_valid", W'(o_valid), W'(m_valid));
    chk("o_ready", W'(o_ready), W'(reset && (!m_valid || i_ready)));
    if (!reset) begin
      chk("rst_o_data", W'(o_data), W'(0));
      chk("rst_o_nwords", W'(o_nwords), W'(0));
      chk("rst_o_partial", W'(o_partial), W'(0));
    end else if (o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected actual=%0h required=none at %0t", o_data, $time);
      end else begin
        chk("frame", {o_partial, o_nwords, o_data}, exp_q[0]);
        if (i_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [NB-1:0] d, input bit l, input bit r);
    i_valid = v;
    i_data  = d;
    i_last  = l;
    i_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic check_frame(input string name, input logic [NB_TOTAL-1:0] d,
                             input int nw, input bit p);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    @(negedge clock);
    chk({name, "_valid"}, W'(o_valid), W'(1));
    chk({name, "_data"}, W'(o_data), W'(d));
    chk({name, "_nwords"}, W'(o_nwords), W'(nw));
    chk({name, "_partial"}, W'(o_partial), W'(p));
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with random inputs on the pins.
    repeat (3) begin
      i_data  = NB'($urandom);
      i_valid = 1'($urandom_range(0, 1));
      i_last  = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("rst_valid", W'(o_valid), W'(0));
      chk("rst_ready", W'(o_ready), W'(0));
      chk("rst_state", W'(o_dbg_state), W'(ST_EMPTY));
    end
    @(posedge clock);
    #1;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", W'(o_ready), W'(1));
    @(posedge clock);
    #1;

    // Full frame.
    for (int i = 1; i <= 8; i++) drive(1'b1, NB'(i), 1'b0, 1'b1);
    check_frame("full", 64'h0807060504030201, 8, 1'b0);
    @(negedge clock);
    chk("full_one_cycle", W'(o_valid), W'(0));
    #1;

    // Early close with i_last.
    drive(1'b1, 8'hAA, 1'b0, 1'b1);
    drive(1'b1, 8'hBB, 1'b0, 1'b1);
    drive(1'b1, 8'hCC, 1'b1, 1'b1);
    check_frame("early", 64'h0000000000CCBBAA, 3, 1'b1);

    // Backpressure: frame completes with i_ready low, then held 10 cycles.
    for (int i = 1; i <= 8; i++) drive(1'b1, NB'(8'h20 + i), 1'b0, 1'b0);
    repeat (10) drive(1'b1, 8'h31, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) drive(1'b1, NB'(8'h30 + i), 1'b0, 1'b1);
    check_frame("bp_resume", 64'h3837363534333231, 8, 1'b0);

    // Streaming 32 samples.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, NB'(i), 1'b0, 1'b1);
      if (i == 23) begin
        @(negedge clock);
        chk("stream_f2_valid", W'(o_valid), W'(1));
        chk("stream_f2_data", W'(o_data), W'(64'h1716151413121110));
        #1;
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-frame.
    for (int i = 0; i < 5; i++) drive(1'b1, NB'(8'h50 + i), 1'b0, 1'b1);
    #2;
    reset   = 1'b0;
    i_valid = 1'b0;
    @(negedge clock);
    chk("midrst_ready", W'(o_ready), W'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) drive(1'b1, NB'(i), 1'b0, 1'b1);
    check_frame("after_rst", 64'h0807060504030201, 8, 1'b0);

    // Randomized traffic against the reference model.
    repeat (400) begin
      drive($urandom_range(0, 9) < 7, NB'($urandom), $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 6);
    end
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    repeat (NW + 2) drive(1'b0, '0, 1'b0, 1'b1);
    @(negedge clock);
    chk("exp_q_drained", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
